mole_round_scheduler: RTL and testbench

Sequences whack-a-mole rounds: waits a down period, picks a pseudo-random set of holes, and drives `mole_positions` for an up window. The up window ends early when the player clears every mole. It sits upstream of the hit-detection block and is its sole source of `mole_positions`. It consumes that block's `full_clear_hit` pulse to end rounds early and, optionally, to speed the game up.

---
 rtl/mole_round_if.sv | 33 +++
 rtl/mole_round_scheduler.sv | 177 +++++++++++++++++
 tb/tb_mole_round_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_round_if.sv
// Game-control inputs and round outputs shared between the round scheduler and the
// hit-detection block. The scheduler takes the master side.
interface mole_round_if #(
  parameter int unsigned NUM_HOLES = 18,
  parameter int unsigned UP_CYCLES = 50_000_000
);
  localparam int unsigned UpW = $clog2(UP_CYCLES + 1);

  logic                 game_in_progress;
  logic                 full_clear_hit;
  logic [NUM_HOLES-1:0] mole_positions;
  logic                 round_done;
  logic [7:0]           round_num;
  logic [UpW-1:0]       up_window;

  modport master (
    input  game_in_progress,
    input  full_clear_hit,
    output mole_positions,
    output round_done,
    output round_num,
    output up_window
  );

  modport slave (
    output game_in_progress,
    output full_clear_hit,
    input  mole_positions,
    input  round_done,
    input  round_num,
    input  up_window
  );
endinterface

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: down period, pseudo-random hole pick, up window.
// Define MOLE_SPEEDUP_EN to shrink the up window after every full clear.
module mole_round_scheduler #(
  parameter int unsigned NUM_HOLES   = 18,
  parameter int unsigned DOWN_CYCLES = 25_000_000,
  parameter int unsigned UP_CYCLES   = 50_000_000,
  parameter int unsigned UP_MIN      = 10_000_000,
  parameter int unsigned UP_STEP     = 2_500_000,
  parameter int unsigned MAX_MOLES   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic          clk,
  input logic          reset,
  mole_round_if.master bus
);
  localparam int unsigned UpW      = $clog2(UP_CYCLES + 1);
  localparam int unsigned DownW    = $clog2(DOWN_CYCLES + 1);
  localparam int unsigned GenLimit = 4 * NUM_HOLES;
  localparam int unsigned GenW     = $clog2(GenLimit);
  localparam int unsigned KW       = $clog2(MAX_MOLES + 1);
  localparam int unsigned IdxW     = $clog2(NUM_HOLES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDown = 2'd1;
  localparam logic [1:0] StGen  = 2'd2;
  localparam logic [1:0] StUp   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [DownW-1:0]     down_q, down_d;
  logic [UpW-1:0]       up_q, up_d;
  logic [GenW-1:0]      gen_q, gen_d;
  logic [KW-1:0]        remain_q, remain_d;
  logic [NUM_HOLES-1:0] pattern_q, pattern_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic                 done_q, done_d;
  logic [7:0]           round_q, round_d;
  logic [UpW-1:0]       upw_q;
  logic [KW-1:0]        k_val;
  logic [IdxW-1:0]      idx;

`ifdef MOLE_SPEEDUP_EN
  logic [UpW-1:0]       upw_d;
`else
  assign upw_q = UpW'(UP_CYCLES);
`endif

  // Galois LFSR, taps 0xB400; runs every cycle regardless of state.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign k_val  = KW'(32'(lfsr_q[15:8]) % MAX_MOLES + 1);
  assign idx    = IdxW'(32'(lfsr_q[7:0]) % NUM_HOLES);

  always_comb begin
    state_d   = state_q;
    down_d    = down_q;
    up_d      = up_q;
    gen_d     = gen_q;
    remain_d  = remain_q;
    pattern_d = pattern_q;
    mole_d    = mole_q;
    done_d    = 1'b0;
    round_d   = round_q;
`ifdef MOLE_SPEEDUP_EN
    upw_d     = upw_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.game_in_progress) begin
          state_d = StDown;
          round_d = 8'd0;
          down_d  = DownW'(DOWN_CYCLES - 1);
`ifdef MOLE_SPEEDUP_EN
          upw_d   = UpW'(UP_CYCLES);
`endif
        end
      end
      StDown: begin
        if (down_q == '0) begin
          state_d   = StGen;
          pattern_d = '0;
          remain_d  = k_val;
          gen_d     = '0;
        end else begin
          down_d = down_q - DownW'(1);
        end
      end
      StGen: begin
        gen_d = gen_q + GenW'(1);
        if (!pattern_q[idx]) begin
          pattern_d[idx] = 1'b1;
          remain_d       = remain_q - KW'(1);
        end
        // Retry budget bounds GEN even if the LFSR keeps hitting occupied holes.
        if (remain_d == '0 || gen_q == GenW'(GenLimit - 1)) begin
          mole_d  = pattern_d;
          up_d    = upw_q - UpW'(1);
          state_d = StUp;
        end
      end
      StUp: begin
        up_d = up_q - UpW'(1);
        if (bus.full_clear_hit || up_q == '0) begin
          state_d = StDown;
          mole_d  = '0;
          done_d  = 1'b1;
          down_d  = DownW'(DOWN_CYCLES - 1);
          if (round_q != 8'hFF) begin
            round_d = round_q + 8'd1;
          end
`ifdef MOLE_SPEEDUP_EN
          if (bus.full_clear_hit) begin
            // Compare first so the subtraction can never wrap.
            if (32'(upw_q) >= UP_MIN + UP_STEP) begin
              upw_d = upw_q - UpW'(UP_STEP);
            end else begin
              upw_d = UpW'(UP_MIN);
            end
          end
`endif
        end
      end
    endcase

    // Game abort overrides everything: silent return to idle, round count kept.
    if (state_q != StIdle && !bus.game_in_progress) begin
      state_d = StIdle;
      mole_d  = '0;
      done_d  = 1'b0;
      round_d = round_q;
`ifdef MOLE_SPEEDUP_EN
      upw_d   = upw_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      lfsr_q    <= LFSR_SEED;
      down_q    <= '0;
      up_q      <= '0;
      gen_q     <= '0;
      remain_q  <= '0;
      pattern_q <= '0;
      mole_q    <= '0;
      done_q    <= 1'b0;
      round_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      down_q    <= down_d;
      up_q      <= up_d;
      gen_q     <= gen_d;
      remain_q  <= remain_d;
      pattern_q <= pattern_d;
      mole_q    <= mole_d;
      done_q    <= done_d;
      round_q   <= round_d;
    end
  end

`ifdef MOLE_SPEEDUP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upw_q <= UpW'(UP_CYCLES);
    end else begin
      upw_q <= upw_d;
    end
  end
`endif

  assign bus.mole_positions = mole_q;
  assign bus.round_done     = done_q;
  assign bus.round_num      = round_q;
  assign bus.up_window      = upw_q;
endmodule

// File: tb/tb_mole_round_scheduler.sv
// Self-checking bench for mole_round_scheduler: round-level reference model driven by a
// model LFSR, with randomized full-clear timing and ignored out-of-window hits.
module tb_mole_round_scheduler;
  localparam int unsigned NH    = 18;
  localparam int unsigned DC    = 4;
  localparam int unsigned UC    = 20;
  localparam int unsigned UMIN  = 8;
  localparam int unsigned USTEP = 5;
  localparam int unsigned MM    = 3;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int unsigned UpW   = $clog2(UC + 1);
  localparam int          NoHit = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mole_round_if #(.NUM_HOLES(NH), .UP_CYCLES(UC)) bus ();

  mole_round_scheduler #(
    .NUM_HOLES  (NH),
    .DOWN_CYCLES(DC),
    .UP_CYCLES  (UC),
    .UP_MIN     (UMIN),
    .UP_STEP    (USTEP),
    .MAX_MOLES  (MM),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_round = 0;
  int exp_win = UC;
  logic [15:0] m_lfsr;

  // Reference LFSR sequence: free-running from the seed.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    bus.game_in_progress = 1'b1;
    step();
    exp_round = 0;
    exp_win   = UC;
    n_cmp++;
    if (bus.round_num !== 8'd0 || bus.up_window !== UpW'(UC)) begin
      n_bad++;
      $display("FAIL game_start: round_num=%0d up_window=%0d, want 0 and %0d",
               bus.round_num, bus.up_window, UC);
    end
  endtask

  // Runs one round from the first DOWN cycle. abort_kind: 0 none, 1 game drop, 2 reset.
  task automatic run_round(input int hit_at, input int abort_kind, input int abort_at);
    logic [NH-1:0] pat;
    int k, rem, n, idx;
    bit hit;
    k = 1;
    for (int i = 0; i < int'(DC); i++) begin
      n_cmp++;
      if (bus.mole_positions !== '0 || (i > 0 && bus.round_done !== 1'b0)) begin
        n_bad++;
        $display("FAIL down_phase cyc %0d: moles=%h done=%b, want moles=0 done=0",
                 i, bus.mole_positions, bus.round_done);
      end
      if (i == int'(DC) - 1) k = 1 + int'(m_lfsr[15:8]) % int'(MM);
      bus.full_clear_hit = 1'($urandom_range(0, 1));
      step();
    end
    pat = '0;
    rem = k;
    n   = 0;
    do begin
      idx = int'(m_lfsr[7:0]) % int'(NH);
      n_cmp++;
      if (bus.mole_positions !== '0 || bus.round_done !== 1'b0) begin
        n_bad++;
        $display("FAIL gen_phase cyc %0d: moles=%h done=%b, want moles=0 done=0",
                 n, bus.mole_positions, bus.round_done);
      end
      if (!pat[idx]) begin
        pat[idx] = 1'b1;
        rem--;
      end
      n++;
      bus.full_clear_hit = 1'($urandom_range(0, 1));
      step();
    end while (rem != 0 && n < int'(4 * NH));
    hit = 1'b0;
    for (int c = 0; c < exp_win; c++) begin
      n_cmp++;
      if (bus.mole_positions !== pat || bus.round_done !== 1'b0 ||
          bus.round_num !== 8'(exp_round)) begin
        n_bad++;
        $display("FAIL up_hold cyc %0d: moles=%h done=%b rnd=%0d, want moles=%h done=0 rnd=%0d",
                 c, bus.mole_positions, bus.round_done, bus.round_num, pat, exp_round);
      end
      n_cmp++;
      if ($countones(bus.mole_positions) < 1 || $countones(bus.mole_positions) > int'(MM)) begin
        n_bad++;
        $display("FAIL up_popcount: got %0d, want 1..%0d", $countones(bus.mole_positions), MM);
      end
      if (abort_kind == 1 && c == abort_at) begin
        bus.full_clear_hit   = 1'b0;
        bus.game_in_progress = 1'b0;
        step();
        n_cmp++;
        if (bus.mole_positions !== '0 || bus.round_done !== 1'b0 ||
            bus.round_num !== 8'(exp_round)) begin
          n_bad++;
          $display("FAIL game_drop: moles=%h done=%b rnd=%0d, want 0 0 %0d",
                   bus.mole_positions, bus.round_done, bus.round_num, exp_round);
        end
        return;
      end
      if (abort_kind == 2 && c == abort_at) begin
        bus.full_clear_hit = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.mole_positions !== '0 || bus.round_done !== 1'b0 ||
            bus.round_num !== 8'd0 || bus.up_window !== UpW'(UC)) begin
          n_bad++;
          $display("FAIL async_reset: moles=%h done=%b rnd=%0d win=%0d, want 0 0 0 %0d",
                   bus.mole_positions, bus.round_done, bus.round_num, bus.up_window, UC);
        end
        bus.game_in_progress = 1'b0;
        step();
        reset = 1'b0;
        step();
        return;
      end
      bus.full_clear_hit = (c == hit_at);
      step();
      bus.full_clear_hit = 1'b0;
      if (c == hit_at) begin
        hit = 1'b1;
        break;
      end
    end
    exp_round = (exp_round < 255) ? exp_round + 1 : 255;
`ifdef MOLE_SPEEDUP_EN
    if (hit) exp_win = (exp_win >= int'(UMIN + USTEP)) ? exp_win - int'(USTEP) : int'(UMIN);
`endif
    n_cmp++;
    if (bus.mole_positions !== '0 || bus.round_done !== 1'b1 ||
        bus.round_num !== 8'(exp_round) || bus.up_window !== UpW'(exp_win)) begin
      n_bad++;
      $display("FAIL round_end hit=%0d: moles=%h done=%b rnd=%0d win=%0d, want 0 1 %0d %0d",
               hit, bus.mole_positions, bus.round_done, bus.round_num, bus.up_window,
               exp_round, exp_win);
    end
  endtask

  task automatic test_reset();
    bus.game_in_progress = 1'b0;
    bus.full_clear_hit   = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.mole_positions !== '0 || bus.round_done !== 1'b0 ||
        bus.round_num !== 8'd0 || bus.up_window !== UpW'(UC)) begin
      n_bad++;
      $display("FAIL reset_values: moles=%h done=%b rnd=%0d win=%0d, want 0 0 0 %0d",
               bus.mole_positions, bus.round_done, bus.round_num, bus.up_window, UC);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_no_hits();
    start_game();
    run_round(NoHit, 0, 0);
    n_cmp++;
    if (bus.round_num !== 8'd1) begin
      n_bad++;
      $display("FAIL first_round_num: got %0d, want 1", bus.round_num);
    end
  endtask

  task automatic test_full_clear();
    int want_win [4];
`ifdef MOLE_SPEEDUP_EN
    want_win = '{15, 10, 8, 8};
`else
    want_win = '{20, 20, 20, 20};
`endif
    for (int r = 0; r < 4; r++) begin
      run_round(3, 0, 0);
      n_cmp++;
      if (bus.up_window !== UpW'(want_win[r])) begin
        n_bad++;
        $display("FAIL speedup_seq r%0d: got %0d, want %0d", r, bus.up_window, want_win[r]);
      end
    end
  endtask

  task automatic test_simultaneous();
    run_round(exp_win - 1, 0, 0);
    run_round(exp_win - 1, 0, 0);
  endtask

  task automatic test_game_end();
    int held;
    run_round(NoHit, 1, 3);
    held = exp_round;
    for (int i = 0; i < 30; i++) begin
      bus.full_clear_hit = 1'($urandom_range(0, 1));
      n_cmp++;
      if (bus.mole_positions !== '0 || bus.round_done !== 1'b0 ||
          bus.round_num !== 8'(held)) begin
        n_bad++;
        $display("FAIL idle_hold cyc %0d: moles=%h done=%b rnd=%0d, want 0 0 %0d",
                 i, bus.mole_positions, bus.round_done, bus.round_num, held);
      end
      step();
    end
    bus.full_clear_hit = 1'b0;
    start_game();
    run_round(2, 0, 0);
  endtask

  task automatic test_reset_mid_up();
    run_round(NoHit, 2, 5);
  endtask

  task automatic test_thousand();
    int h;
    start_game();
    for (int r = 0; r < 1000; r++) begin
      h = ($urandom_range(0, 7) == 0) ? NoHit : int'($urandom_range(0, 3));
      run_round(h, 0, 0);
    end
    n_cmp++;
    if (bus.round_num !== 8'd255) begin
      n_bad++;
      $display("FAIL round_saturate: got %0d, want 255", bus.round_num);
    end
  endtask

  initial begin
    test_reset();
    test_no_hits();
    test_full_clear();
    test_simultaneous();
    test_game_end();
    test_reset_mid_up();
    test_thousand();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
